// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared width default and processor register map for the NIC
package nic_pkg;

    localparam int DEFAULT_DATA_W = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_buf.sv
// rtl/nic_buf.sv - one-entry packet register with full flag and load/clear strobes
module nic_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [0:W-1] i_data,
    output logic [0:W-1] o_data,
    output logic         o_full
);

    logic [0:W-1] r_data;
    logic         r_full;

    // Data is kept after a clear so a late read returns the last packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - processor-to-router NIC with one-entry inbound and outbound channels
module cardinal_nic
    import nic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr_nic,
    input  logic [0:DATA_W-1] d_in_nic,
    output logic [0:DATA_W-1] d_out_nic,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    logic              w_rd;
    logic              w_wr;
    logic              w_in_load;
    logic              w_in_clear;
    logic              w_out_load;
    logic              w_send;
    logic              w_in_full;
    logic              w_out_full;
    logic [0:DATA_W-1] w_in_data;
    logic [0:DATA_W-1] w_out_data;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn &  nicWrEn;

    assign net_ri     = ~w_in_full;
    assign w_in_load  = net_si & ~w_in_full;
    assign w_in_clear = w_rd & (addr_nic == ADDR_IN_BUF) & w_in_full;

    // A full output buffer blocks writes, so load and send never coincide.
    assign w_out_load = w_wr & (addr_nic == ADDR_OUT_BUF) & ~w_out_full;
    assign w_send     = w_out_full & net_ro & (w_out_data[0] == net_polarity);

    assign net_so = w_send;
    assign net_do = w_out_data;

    nic_buf #(.W(DATA_W)) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_in_load),
        .i_clear (w_in_clear),
        .i_data  (net_di),
        .o_data  (w_in_data),
        .o_full  (w_in_full)
    );

    nic_buf #(.W(DATA_W)) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_clear (w_send),
        .i_data  (d_in_nic),
        .o_data  (w_out_data),
        .o_full  (w_out_full)
    );

    // Status words carry the flag in the least significant (last) bit.
    always_comb begin
        d_out_nic = '0;
        if (w_rd) begin
            case (addr_nic)
                ADDR_IN_BUF:   d_out_nic = w_in_data;
                ADDR_IN_STAT:  d_out_nic[DATA_W-1] = w_in_full;
                ADDR_OUT_STAT: d_out_nic[DATA_W-1] = w_out_full;
                default:       d_out_nic = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - vector table, scoreboard traffic and reset corner cases for cardinal_nic
`timescale 1ns/100ps
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr_nic;
    logic [63:0] d_in_nic;
    logic [63:0] d_out_nic;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int n_checks = 0;
    int n_errors = 0;

    cardinal_nic #(.DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_nic     (addr_nic),
        .d_in_nic     (d_in_nic),
        .d_out_nic    (d_out_nic),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  addr;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic [63:0] x_dout;
        logic        x_ri;
        logic        x_so;
        logic [63:0] x_do;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] P = 64'h8000_0000_0000_00AA;
    localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          N = 20;

    function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] addr,
                                input logic [63:0] din, input logic si, input logic [63:0] di,
                                input logic ro, input logic pol, input logic [63:0] x_dout,
                                input logic x_ri, input logic x_so, input logic [63:0] x_do);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.x_dout = x_dout; v.x_ri = x_ri; v.x_so = x_so; v.x_do = x_do;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        nicEn = 0; nicWrEn = 0; addr_nic = 2'b00; d_in_nic = '0;
        net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
    endtask

    logic [63:0] sb_in_q[$];
    logic [63:0] sb_out_q[$];
    logic [63:0] cur_in;
    logic [63:0] cur_out;
    logic        have_in;
    int          n_in_sent, n_in_recv, n_out_sent, n_out_recv, phase;

    initial begin
        idle();
        reset = 1'b1;
        #15;
        chk("rst ri",   {63'b0, net_ri}, 64'h1);
        chk("rst so",   {63'b0, net_so}, 64'h0);
        chk("rst do",   net_do, 64'h0);
        chk("rst dout", d_out_nic, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,2'b11,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,2'b00,0,1,D,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,2'b00,0,1,64'h1234,0,0, D,0,0,0));
        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0,0, D,1,0,0));
        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,2'b10,P,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk(1,0,2'b11,0,0,0,1,0, 1,1,0,P));
        vecs.push_back(mk(1,0,2'b10,0,0,0,1,0, 0,1,0,P));
        vecs.push_back(mk(0,0,2'b00,0,0,0,1,1, 0,1,1,P));
        vecs.push_back(mk(1,0,2'b11,0,0,0,1,1, 0,1,0,P));
        vecs.push_back(mk(1,1,2'b10,1,0,0,0,0, 0,1,0,P));
        vecs.push_back(mk(1,1,2'b10,2,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2'b11,0,0,0,0,0, 1,1,0,1));
        vecs.push_back(mk(1,1,2'b10,3,0,0,1,0, 0,1,1,1));
        vecs.push_back(mk(1,0,2'b11,0,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,1,2'b00,F,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,1,2'b01,F,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,1,2'b11,F,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2'b11,0,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0,0, D,1,0,1));
        vecs.push_back(mk(1,1,2'b10,5,0,0,0,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2'b00,0,1,64'hCAFE,1,0, D,1,1,5));
        vecs.push_back(mk(1,0,2'b01,0,0,0,1,0, 1,0,0,5));
        vecs.push_back(mk(1,0,2'b11,0,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(0,0,2'b00,0,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(1,0,2'b00,0,0,0,0,0, 64'hCAFE,0,0,5));
        vecs.push_back(mk(1,0,2'b01,0,0,0,0,0, 0,1,0,5));

        foreach (vecs[i]) begin
            @(negedge clk);
            nicEn = vecs[i].en; nicWrEn = vecs[i].wr; addr_nic = vecs[i].addr;
            d_in_nic = vecs[i].din; net_si = vecs[i].si; net_di = vecs[i].di;
            net_ro = vecs[i].ro; net_polarity = vecs[i].pol;
            #2;
            chk($sformatf("v%0d dout", i), d_out_nic, vecs[i].x_dout);
            chk($sformatf("v%0d ri", i), {63'b0, net_ri}, {63'b0, vecs[i].x_ri});
            chk($sformatf("v%0d so", i), {63'b0, net_so}, {63'b0, vecs[i].x_so});
            chk($sformatf("v%0d do", i), net_do, vecs[i].x_do);
        end

        // Scoreboard traffic: router producer, polling processor, random router back-pressure.
        have_in = 0; n_in_sent = 0; n_in_recv = 0; n_out_sent = 0; n_out_recv = 0; phase = 0;
        cur_in = '0; cur_out = '0;
        for (int cyc = 0; cyc < 3000 && !(n_in_recv == N && n_out_recv == N); cyc++) begin
            @(negedge clk);
            idle();
            if (!have_in && n_in_sent < N) begin
                cur_in = {$urandom(), $urandom()};
                have_in = 1;
            end
            net_si = have_in & 1'($urandom_range(0, 1));
            net_di = cur_in;
            net_ro = 1'($urandom_range(0, 1));
            net_polarity = 1'($urandom_range(0, 1));
            nicEn = 1;
            case (phase)
                0: addr_nic = 2'b01;
                1: addr_nic = 2'b00;
                2: addr_nic = 2'b11;
                default: begin nicWrEn = 1; addr_nic = 2'b10; d_in_nic = cur_out; end
            endcase
            #2;
            if (net_si && net_ri) begin
                sb_in_q.push_back(cur_in);
                have_in = 0;
                n_in_sent++;
            end
            if (net_so) begin
                if (sb_out_q.size() == 0) chk("sb out unexpected send", net_do, 64'hx);
                else chk($sformatf("sb out %0d", n_out_recv), net_do, sb_out_q.pop_front());
                n_out_recv++;
            end
            case (phase)
                0: phase = (d_out_nic == 64'h1) ? 1 : 2;
                1: begin
                    if (sb_in_q.size() == 0) chk("sb in unexpected full", d_out_nic, 64'hx);
                    else chk($sformatf("sb in %0d", n_in_recv), d_out_nic, sb_in_q.pop_front());
                    n_in_recv++;
                    phase = 2;
                end
                2: begin
                    if (d_out_nic == 64'h0 && n_out_sent < N) begin
                        cur_out = {$urandom(), $urandom()};
                        phase = 3;
                    end else begin
                        phase = 0;
                    end
                end
                default: begin
                    sb_out_q.push_back(cur_out);
                    n_out_sent++;
                    phase = 0;
                end
            endcase
        end
        chk("sb in count",  64'(n_in_recv),  64'(N));
        chk("sb out count", 64'(n_out_recv), 64'(N));

        // Asynchronous reset mid-cycle with both channels full and a send pending.
        @(negedge clk);
        idle();
        @(negedge clk);
        nicEn = 1; nicWrEn = 1; addr_nic = 2'b10; d_in_nic = 64'h8000_0000_0000_0001;
        net_si = 1; net_di = 64'h77;
        @(negedge clk);
        idle();
        nicEn = 1; addr_nic = 2'b01; net_ro = 1; net_polarity = 1;
        #2;
        chk("pre-rst in stat", d_out_nic, 64'h1);
        chk("pre-rst so", {63'b0, net_so}, 64'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid-rst so", {63'b0, net_so}, 64'h0);
        chk("mid-rst ri", {63'b0, net_ri}, 64'h1);
        chk("mid-rst do", net_do, 64'h0);
        chk("mid-rst in stat", d_out_nic, 64'h0);
        addr_nic = 2'b11;
        #1;
        chk("mid-rst out stat", d_out_nic, 64'h0);
        net_si = 1; net_di = 64'h99;
        @(negedge clk);
        idle();
        reset = 1'b0;
        @(negedge clk);
        nicEn = 1; addr_nic = 2'b01;
        #2;
        chk("post-rst in stat", d_out_nic, 64'h0);
        chk("post-rst ri", {63'b0, net_ri}, 64'h1);
        @(negedge clk);
        nicEn = 1; addr_nic = 2'b11;
        #2;
        chk("post-rst out stat", d_out_nic, 64'h0);
        chk("post-rst do", net_do, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
